// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite signal bundle for axil_reg_slave.
// The master modport issues requests; the slave modport returns readies and responses.
`timescale 1ns/1ps
interface axil_reg_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) ();
  logic [ADDR_W-1:0]   AWADDR;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave with a byte-strobed register file; reg 0 drives out_port.
// Define AXIL_IN_PORT_EN to add a synchronised read-only in_port at word index NUM_REGS.
`timescale 1ns/1ps
module axil_reg_slave #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8,
  parameter int NUM_REGS = 8,
  parameter int OUT_W    = 16
) (
  input  logic              ACLK,
  input  logic              ARESET,
  axil_reg_slave_if.slave   s_axil,
`ifdef AXIL_IN_PORT_EN
  input  logic [DATA_W-1:0] in_port,
`endif
  output logic [OUT_W-1:0]  out_port
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wstate_e;
  typedef enum logic { R_IDLE, R_VALID } rstate_e;

  function automatic int word_idx(input logic [ADDR_W-1:0] addr);
    return int'(addr >> LSB);
  endfunction

  wstate_e             wstate_q, wstate_d;
  logic                aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [ADDR_W-1:0]   aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                awready_q, awready_d, wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];

  rstate_e             rstate_q, rstate_d;
  logic                arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  int                  widx, ridx;

`ifdef AXIL_IN_PORT_EN
  logic [DATA_W-1:0]   in_meta_q, in_sync_q;
`endif

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    wstate_d  = wstate_q;
    aw_full_d = aw_full_q;
    aw_addr_d = aw_addr_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    widx      = 0;

    if (s_axil.AWVALID && awready_q) begin
      aw_full_d = 1'b1;
      aw_addr_d = s_axil.AWADDR;
    end
    if (s_axil.WVALID && wready_q) begin
      w_full_d = 1'b1;
      wdata_d  = s_axil.WDATA;
      wstrb_d  = s_axil.WSTRB;
    end

    case (wstate_q)
      W_IDLE: begin
        // Commit on the edge where the second buffer fills, using the freshly captured values.
        if (aw_full_d && w_full_d) begin
          widx     = word_idx(aw_addr_d);
          bvalid_d = 1'b1;
          bresp_d  = RESP_SLVERR;
          wstate_d = W_RESP;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (widx == i) begin
              bresp_d = RESP_OKAY;
              for (int b = 0; b < STRB_W; b++) begin
                if (wstrb_d[b]) regs_d[i][8*b +: 8] = wdata_d[8*b +: 8];
              end
            end
          end
        end
      end
      W_RESP: begin
        if (s_axil.BREADY) begin
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase

    awready_d = (wstate_d == W_IDLE) && !aw_full_d;
    wready_d  = (wstate_d == W_IDLE) && !w_full_d;
  end

  always_comb begin
    rstate_d = rstate_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    ridx     = 0;

    case (rstate_q)
      R_IDLE: begin
        // Reads sample regs_q, so a same-edge write commit is not yet visible.
        if (s_axil.ARVALID && arready_q) begin
          ridx     = word_idx(s_axil.ARADDR);
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (ridx == i) begin
              rdata_d = regs_q[i];
              rresp_d = RESP_OKAY;
            end
          end
`ifdef AXIL_IN_PORT_EN
          if (ridx == NUM_REGS) begin
            rdata_d = in_sync_q;
            rresp_d = RESP_OKAY;
          end
`endif
          rvalid_d = 1'b1;
          rstate_d = R_VALID;
        end
      end
      R_VALID: begin
        if (s_axil.RREADY) begin
          rvalid_d = 1'b0;
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase

    arready_d = (rstate_d == R_IDLE);
  end

  // NOTE: state is updated only with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      wstate_q  <= W_IDLE;
      aw_full_q <= 1'b0;
      aw_addr_q <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      // NOTE: the register file is small and must read 0 after reset, so it is reset like any flop.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
`ifdef AXIL_IN_PORT_EN
      in_meta_q <= '0;
      in_sync_q <= '0;
`endif
    end else begin
      wstate_q  <= wstate_d;
      aw_full_q <= aw_full_d;
      aw_addr_q <= aw_addr_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
`ifdef AXIL_IN_PORT_EN
      in_meta_q <= in_port;
      in_sync_q <= in_meta_q;
`endif
    end
  end

  assign s_axil.AWREADY = awready_q;
  assign s_axil.WREADY  = wready_q;
  assign s_axil.BVALID  = bvalid_q;
  assign s_axil.BRESP   = bresp_q;
  assign s_axil.ARREADY = arready_q;
  assign s_axil.RVALID  = rvalid_q;
  assign s_axil.RRESP   = rresp_q;
  assign s_axil.RDATA   = rdata_q;
  assign out_port       = regs_q[0][OUT_W-1:0];

endmodule

// File: tb/tb_axil_reg_slave.sv
// Randomised and directed bench for axil_reg_slave, checked against an array-based register model.
`timescale 1ns/1ps
module tb_axil_reg_slave;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 8;
  localparam int NUM_REGS = 8;
  localparam int OUT_W    = 16;
  localparam logic [31:0] IN_VAL = 32'hC0DE_1234;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic [OUT_W-1:0] out_port;

  axil_reg_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef AXIL_IN_PORT_EN
  logic [DATA_W-1:0] in_port;
`endif

  axil_reg_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .OUT_W(OUT_W)
  ) dut (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .s_axil  (bus),
`ifdef AXIL_IN_PORT_EN
    .in_port (in_port),
`endif
    .out_port(out_port)
  );

  always #5 ACLK = ~ACLK;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [NUM_REGS];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reference model: word-addressed array, byte masks built from the strobes.
  function automatic logic [1:0] model_write(input logic [7:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int idx = int'(addr) / 4;
    logic [31:0] mask = 32'h0;
    if (idx >= NUM_REGS) return 2'b10;
    for (int b = 0; b < 4; b++) if (strb[b]) mask = mask | (32'hFF << (8 * b));
    model[idx] = (model[idx] & ~mask) | (data & mask);
    return 2'b00;
  endfunction

  function automatic void model_read(input logic [7:0] addr, output logic [31:0] data,
                                     output logic [1:0] resp);
    int idx = int'(addr) / 4;
    data = 32'h0;
    resp = 2'b10;
    if (idx < NUM_REGS) begin
      data = model[idx];
      resp = 2'b00;
    end
`ifdef AXIL_IN_PORT_EN
    if (idx == NUM_REGS) begin
      data = IN_VAL;
      resp = 2'b00;
    end
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NUM_REGS; i++) model[i] = 32'h0;
  endfunction

  function automatic logic sel_ready(input int which);
    case (which)
      0:       return bus.AWREADY;
      1:       return bus.WREADY;
      default: return bus.ARREADY;
    endcase
  endfunction

  task automatic wait_ready(input int which, input string tag);
    int n = 0;
    while (!sel_ready(which)) begin
      tick();
      n++;
      if (n > 50) begin
        check(tag, 64'd0, 64'd1);
        return;
      end
    end
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    logic [1:0] exp_resp;
    fork
      begin
        repeat (aw_dly) tick();
        bus.AWADDR  = addr;
        bus.AWVALID = 1'b1;
        wait_ready(0, "awready_timeout");
        tick();
        bus.AWVALID = 1'b0;
      end
      begin
        repeat (w_dly) tick();
        bus.WDATA  = data;
        bus.WSTRB  = strb;
        bus.WVALID = 1'b1;
        wait_ready(1, "wready_timeout");
        tick();
        bus.WVALID = 1'b0;
      end
    join
    exp_resp = model_write(addr, data, strb);
    check("bvalid_at_commit", 64'(bus.BVALID), 64'd1);
    check("bresp", 64'(bus.BRESP), 64'(exp_resp));
    check("out_port_after_commit", 64'(out_port), 64'(model[0][OUT_W-1:0]));
    for (int k = 0; k < b_dly; k++) begin
      tick();
      check("bvalid_hold", 64'(bus.BVALID), 64'd1);
      check("bresp_hold", 64'(bus.BRESP), 64'(exp_resp));
      check("aw_w_ready_in_resp", 64'({bus.AWREADY, bus.WREADY}), 64'd0);
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    check("bvalid_after_b", 64'(bus.BVALID), 64'd0);
    check("aw_w_ready_after_b", 64'({bus.AWREADY, bus.WREADY}), 64'h3);
  endtask

  task automatic do_read(input logic [7:0] addr, input int r_dly);
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    model_read(addr, exp_data, exp_resp);
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    wait_ready(2, "arready_timeout");
    tick();
    bus.ARVALID = 1'b0;
    check("rvalid", 64'(bus.RVALID), 64'd1);
    check("rdata", 64'(bus.RDATA), 64'(exp_data));
    check("rresp", 64'(bus.RRESP), 64'(exp_resp));
    for (int k = 0; k < r_dly; k++) begin
      tick();
      check("rdata_hold", 64'(bus.RDATA), 64'(exp_data));
      check("rvalid_arready_hold", 64'({bus.RVALID, bus.ARREADY}), 64'h2);
    end
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
    check("rvalid_arready_after_r", 64'({bus.RVALID, bus.ARREADY}), 64'h1);
  endtask

  initial begin
    logic [31:0] old0;
    bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 1'b0;
    bus.BREADY = 1'b0; bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
`ifdef AXIL_IN_PORT_EN
    in_port = IN_VAL;
`endif
    model_reset();
    ARESET = 1'b0;
    repeat (3) tick();
    check("reset_readies", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'd0);
    check("reset_valids", 64'({bus.BVALID, bus.RVALID}), 64'd0);
    check("reset_resps", 64'({bus.BRESP, bus.RRESP}), 64'd0);
    check("reset_rdata", 64'(bus.RDATA), 64'd0);
    check("reset_out_port", 64'(out_port), 64'd0);
    ARESET = 1'b1;
    tick();
    check("readies_after_release", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'h7);

    // Same-cycle AW/W to reg 0.
    do_write(8'h00, 32'h0000_A5C3, 4'hF, 0, 0, 0);
    check("out_port_a5c3", 64'(out_port), 64'hA5C3);
    // W three cycles ahead of AW, single strobe.
    do_write(8'h04, 32'hFFFF_FFFF, 4'h2, 3, 0, 0);
    do_read(8'h04, 0);
    // AW ahead of W.
    do_write(8'h09, 32'h1357_9BDF, 4'hC, 0, 2, 1);
    // Out-of-range write and read.
    do_write(8'h20, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_read(8'h20, 0);
    // Long B back-pressure.
    do_write(8'h1C, 32'h8765_4321, 4'hF, 1, 1, 5);
    do_read(8'h1C, 2);

    // Read of reg 0 accepted on the same edge a write to reg 0 commits.
    old0 = model[0];
    bus.AWADDR = 8'h00; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    check("w_ready_before_collide", 64'({bus.WREADY, bus.ARREADY}), 64'h3);
    bus.WDATA = 32'h0F0F_7E7E; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    bus.ARADDR = 8'h00; bus.ARVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
    void'(model_write(8'h00, 32'h0F0F_7E7E, 4'hF));
    check("collide_bvalid", 64'(bus.BVALID), 64'd1);
    check("collide_rdata_old", 64'(bus.RDATA), 64'(old0));
    check("collide_out_port_new", 64'(out_port), 64'h7E7E);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("collide_rdata_hold", 64'(bus.RDATA), 64'(old0));
      check("collide_arready_low", 64'(bus.ARREADY), 64'd0);
    end
    bus.RREADY = 1'b1; bus.BREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0; bus.BREADY = 1'b0;
    check("collide_done", 64'({bus.BVALID, bus.RVALID, bus.ARREADY, bus.AWREADY}), 64'h3);
    do_read(8'h00, 0);

    // Randomised traffic.
    for (int n = 0; n < 60; n++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 39));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end

    // Reset while the write side is in W_RESP and the read side in R_VALID.
    bus.AWADDR = 8'h00; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h0000_BEEF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.ARADDR = 8'h04; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    check("pre_reset_valids", 64'({bus.BVALID, bus.RVALID}), 64'h3);
    ARESET = 1'b0;
    #1;
    model_reset();
    check("mid_reset_valids", 64'({bus.BVALID, bus.RVALID}), 64'd0);
    check("mid_reset_out_port", 64'(out_port), 64'd0);
    check("mid_reset_readies", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'd0);
    tick();
    ARESET = 1'b1;
    tick();
    check("readies_after_rerelease", 64'({bus.AWREADY, bus.WREADY, bus.ARREADY}), 64'h7);
    for (int i = 0; i <= NUM_REGS; i++) do_read(8'(4 * i), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axil_reg_slave.md
Name: axil_reg_slave

Overview:
Parametrised AXI4-Lite slave with a byte-strobed register file of NUM_REGS words of DATA_W bits.
- Register 0's low OUT_W bits drive out_port, which replaces the fixed 16-bit LED output.
- Independent AW/W capture, full valid/ready handshakes, 2-bit BRESP/RRESP, and SLVERR on out-of-range addresses.
- Sits behind the PS/interconnect master as a generic control/status peripheral.

Parameters:
DATA_W, 32, data bus width; must be 32 or 64.
ADDR_W, 8, address bus width in bits.
NUM_REGS, 8, number of read/write registers; 1..2^(ADDR_W-log2(DATA_W/8)).
OUT_W, 16, width of out_port; must be <= DATA_W.

Ports:
ACLK  in  1  clock
ARESET  in  1  reset, asynchronous, active-low
AWADDR  in  ADDR_W  write address (byte)
AWVALID  in  1  write address valid
AWREADY  out  1  write address ready
WDATA  in  DATA_W  write data
WSTRB  in  DATA_W/8  byte strobes
WVALID  in  1  write data valid
WREADY  out  1  write data ready
BRESP  out  2  write response (00 OKAY, 10 SLVERR)
BVALID  out  1  write response valid
BREADY  in  1  write response ready
ARADDR  in  ADDR_W  read address (byte)
ARVALID  in  1  read address valid
ARREADY  out  1  read address ready
RDATA  out  DATA_W  read data
RRESP  out  2  read response
RVALID  out  1  read valid
RREADY  in  1  read ready
out_port  out  OUT_W  reg[0][OUT_W-1:0], registered

Behaviour:
Reset (ARESET low, async):
- All registers = 0; out_port = 0.
- AWREADY = WREADY = ARREADY = 0 during reset; all three = 1 in the first cycle after release.
- BVALID = RVALID = 0; BRESP = RRESP = 00; RDATA = 0.
- Reset mid-transaction aborts it; no partial write survives.

Decode:
- Word index = addr[ADDR_W-1:log2(DATA_W/8)]; low address bits are ignored.
- Index >= NUM_REGS is out of range.

Write FSM, states W_IDLE, W_RESP:
- W_IDLE: AW and W channels are captured independently, each into a one-entry buffer.
  - AWREADY = 1 while the AW buffer is empty; WREADY = 1 while the W buffer is empty. Each drops the cycle after its own handshake.
  - AW before W, W before AW, and both in the same cycle are all legal.
- Commit: at the clock edge where the second buffer fills (or both fill together), the write commits.
  - In range: each byte lane with WSTRB[i] = 1 is written; other lanes are unchanged.
  - Out of range: no register changes.
  - Same edge: BVALID goes to 1, BRESP = 00 (in range) or 10 (out of range), and the FSM enters W_RESP.
- W_RESP: BVALID and BRESP are held stable until BREADY = 1.
  - On the B handshake edge, both buffers clear and the FSM returns to W_IDLE.
  - AWREADY and WREADY are 1 in the following cycle.
- out_port updates at the commit edge when reg 0 is written.

Read FSM, states R_IDLE, R_VALID:
- R_IDLE: ARREADY = 1.
  - On the AR handshake edge: RDATA = register value (0 if out of range), RRESP = 00 or 10, RVALID = 1, ARREADY = 0, FSM enters R_VALID.
- R_VALID: RDATA, RRESP and RVALID are held until RREADY = 1.
  - On the R handshake edge: RVALID = 0 and ARREADY = 1 (back-to-back reads allowed, one per two cycles).
- Read and write paths are fully independent.
  - A read accepted on the same edge as a write commit to the same register returns the pre-write value.

Optional Feature:
AXIL_IN_PORT_EN
- Defined: adds port in_port (input, DATA_W).
  - in_port passes through a two-flop ACLK synchroniser (reset 0).
  - It is read-only at word index NUM_REGS; a read returns the synchronised value with RRESP 00.
  - A write to that index changes nothing and returns BRESP 10.
- Undefined: in_port is absent, and index NUM_REGS is out of range like any other index >= NUM_REGS.

Test Plan:
1. Reset, then AW addr 0x00 and W 0x0000_A5C3 / WSTRB 0xF in the same cycle, BREADY = 1 -> BVALID next cycle with BRESP 00; out_port = 0xA5C3.
2. W 0xFFFF_FFFF presented 3 cycles before AW 0x04, WSTRB 0x2 -> reg1 = 0x0000_FF00 after commit; read 0x04 returns 0x0000_FF00 with RRESP 00.
3. Write addr 0x20 (index 8, NUM_REGS = 8) -> BRESP 10, no register changes; read 0x20 -> RDATA 0, RRESP 10.
4. Hold BREADY = 0 for 5 cycles after commit -> BVALID and BRESP stable, AWREADY/WREADY stay 0; both return to 1 the cycle after the BREADY handshake.
5. Read 0x00 with RREADY held low 4 cycles, while a write to reg 0 commits on the AR edge -> RDATA holds the old value until the handshake; ARREADY = 0 throughout.
6. Assert ARESET low during W_RESP and R_VALID -> BVALID and RVALID drop immediately, registers = 0, out_port = 0; all three READY outputs = 1 one cycle after release.
